lvds_rx: RTL
============

# lvds_rx

Receive-side counterpart of the panel LVDS link: recovers pixel data from four 7:1 serial data lanes plus the serialized clock lane, all sampled one bit per cycle in the bit-clock domain. It aligns to the 7-bit word boundary using the clock-lane pattern, tracks lock, and unpacks each word set into 8-bit R/G/B, sync, DEN and CTRL with a one-cycle valid strobe. It sits between the LVDS input buffers (already converted to single-ended, bit-clock sampled) and the pixel pipeline.

## Interface
- LOCK_CNT, 4: consecutive boundary matches required before declaring lock (≥1)
- ERR_MAX, 3: consecutive boundary mismatches while locked that drop lock (≥1)
- clk  in  1  bit clock, one serial bit per lane per cycle
- reset  in  1  synchronous, active-high
- rx0..rx3  in  1 each  serial data lanes 0..3
- rxclk  in  1  serialized clock lane, sampled as data
- r, g, b  out  8 each  recovered pixel colour
- hsync, vsync, den, ctrl  out  1 each  recovered control bits
- pix_valid  out  1  one-cycle strobe, outputs above valid
- locked  out  1  word alignment established
- word_err  out  8  saturating count of clock-word mismatches while locked

## Operation
- Per lane, including rxclk, a 7-bit shift register: sr <= {sr[5:0], in}. The first-transmitted bit ends in bit 6.
- Clock pattern CPAT = 7'b1100011.
- Word mapping, bits [6:0]:
  - lane0 = {g[2], r[7:2]}
  - lane1 = {b[3:2], g[7:3]}
  - lane2 = {den, vsync, hsync, b[7:4]}
  - lane3 = {ctrl, b[1:0], g[1:0], r[1:0]}
- Phase counter ph (0..6, wraps 6→0). A boundary is a cycle with ph==0.
- States:
  - SEARCH: every cycle, compare sr_clk to CPAT. On a match, ph <= 1, cnt <= 1, go to VERIFY; if LOCK_CNT==1, go to LOCKED instead.
  - VERIFY: at each boundary, a match increments cnt; when cnt reaches LOCK_CNT, go to LOCKED. Any mismatch returns to SEARCH. No pixels are output.
  - LOCKED: at each boundary:
    - Match: miss <= 0; register unpacked fields; pix_valid <= 1.
    - Mismatch: word dropped, miss++, word_err++ (saturates at 255). When miss reaches ERR_MAX, go to SEARCH and clear miss.
- ph free-runs mod 7 outside SEARCH. In SEARCH, ph is don't-care until a match.
- Field outputs hold their last value between strobes.
- word_err clears only on reset.
- Reset values:
  - state SEARCH; ph, cnt, miss 0; all shift registers 0.
  - r, g, b = 0; hsync, vsync, den, ctrl = 0; pix_valid = 0; locked = 0; word_err = 0.
- reset mid-word or mid-lock: immediate return to the reset state on the next edge; no pix_valid in that cycle.

## Timing
- Latency: the last bit of a word is captured at edge E and the boundary is evaluated in cycle E..E+1. Fields and pix_valid update at edge E+1 and are visible for exactly one cycle. pix_valid is never high in two adjacent cycles, and has a 7-cycle period while locked and error-free.
- locked is registered: it rises the cycle after the LOCK_CNT-th match and falls the cycle after the ERR_MAX-th miss.
- Lock acquisition from a clean stream: first match at boundary B0, locked high after boundary B0 + 7·(LOCK_CNT−1) + 1 cycle.
- A match that coincides with a loss-of-lock transition is not re-evaluated as a SEARCH match in the same cycle. Search resumes on the next cycle.
- A false CPAT match inside data during SEARCH is resolved by VERIFY failing, then SEARCH resuming.

## Test plan
- Reset, then a continuous stream with r=8'hA5, g=8'h3C, b=8'hF0, hsync=1, vsync=0, den=1, ctrl=0 and the lane-0 start offset by 3 bits → locked=1 after 4 clock words. Thereafter pix_valid every 7 cycles with exactly those values; word_err=0.
- Incrementing pixel (r=g=b=n) for 20 words → outputs r=g=b=n in order, with latency 1 edge after each word's last bit.
- While locked, corrupt one clock word → that pixel is not strobed, word_err=1, locked stays 1. Corrupt 3 consecutive words → locked falls, then re-lock after 4 clean words; word_err=4.
- During VERIFY, corrupt the 2nd clock word → back to SEARCH, no pix_valid, locked stays 0, word_err=0.
- Assert reset for 1 cycle mid-word while locked → all outputs 0 the next cycle, then a full re-acquisition of 4 words.
- Hold rxclk=0 with random data → locked never asserts, pix_valid stays 0.

Source files
------------

// File: rtl/lvds_rx.sv
// LVDS 7:1 receiver: aligns to the serialized clock-lane pattern, tracks lock,
// and unpacks four data lanes into one registered pixel per clock word.
module lvds_rx #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_MAX  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx0,
    input  logic       rx1,
    input  logic       rx2,
    input  logic       rx3,
    input  logic       rxclk,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hsync,
    output logic       vsync,
    output logic       den,
    output logic       ctrl,
    output logic       pix_valid,
    output logic       locked,
    output logic [7:0] word_err
);

    localparam int unsigned CNT_W  = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W = $clog2(ERR_MAX + 1);
    localparam logic [6:0]  CPAT    = 7'b1100011;
    localparam logic [2:0]  PH_LAST = 3'd6;

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t              state;
    state_t              state_next;
    logic [6:0]          sr0;
    logic [6:0]          sr1;
    logic [6:0]          sr2;
    logic [6:0]          sr3;
    logic [6:0]          sr_clk;
    logic [2:0]          ph;
    logic [2:0]          ph_next;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [MISS_W-1:0]   miss;
    logic [MISS_W-1:0]   miss_next;
    logic                boundary;
    logic                clk_match;
    logic                take_pix;
    logic                drop_word;

    assign boundary  = (ph == 3'd0);
    assign clk_match = (sr_clk == CPAT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SEARCH: begin
                if (clk_match) begin
                    state_next = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (!clk_match) begin
                        state_next = SEARCH;
                    end else if (cnt + CNT_W'(1) == CNT_W'(LOCK_CNT)) begin
                        state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (boundary && !clk_match && (miss + MISS_W'(1) == MISS_W'(ERR_MAX))) begin
                    state_next = SEARCH;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    // A SEARCH match is treated as phase 0, so the next boundary falls 7 cycles later.
    always_comb begin
        ph_next   = (ph == PH_LAST) ? 3'd0 : ph + 3'd1;
        cnt_next  = cnt;
        miss_next = miss;
        take_pix  = 1'b0;
        drop_word = 1'b0;
        unique case (state)
            SEARCH: begin
                ph_next = 3'd0;
                if (clk_match) begin
                    ph_next  = 3'd1;
                    cnt_next = CNT_W'(1);
                end
            end
            VERIFY: begin
                if (boundary && clk_match) begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (clk_match) begin
                        miss_next = '0;
                        take_pix  = 1'b1;
                    end else begin
                        drop_word = 1'b1;
                        miss_next = (miss + MISS_W'(1) == MISS_W'(ERR_MAX)) ? '0 : miss + MISS_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr0       <= '0;
            sr1       <= '0;
            sr2       <= '0;
            sr3       <= '0;
            sr_clk    <= '0;
            ph        <= '0;
            cnt       <= '0;
            miss      <= '0;
            r         <= '0;
            g         <= '0;
            b         <= '0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            den       <= 1'b0;
            ctrl      <= 1'b0;
            pix_valid <= 1'b0;
            locked    <= 1'b0;
            word_err  <= '0;
        end else begin
            sr0       <= {sr0[5:0], rx0};
            sr1       <= {sr1[5:0], rx1};
            sr2       <= {sr2[5:0], rx2};
            sr3       <= {sr3[5:0], rx3};
            sr_clk    <= {sr_clk[5:0], rxclk};
            ph        <= ph_next;
            cnt       <= cnt_next;
            miss      <= miss_next;
            pix_valid <= take_pix;
            locked    <= (state_next == LOCKED);
            if (drop_word && (word_err != 8'hFF)) begin
                word_err <= word_err + 8'd1;
            end
            // Fields hold their last value between strobes.
            if (take_pix) begin
                r     <= {sr0[5:0], sr3[1:0]};
                g     <= {sr1[4:0], sr0[6], sr3[3:2]};
                b     <= {sr2[3:0], sr1[6:5], sr3[5:4]};
                hsync <= sr2[4];
                vsync <= sr2[5];
                den   <= sr2[6];
                ctrl  <= sr3[6];
            end
        end
    end

endmodule
